// File: rtl/median3_stream_filter.sv
// median3_stream_filter
//   Streaming 3-tap median filter. Keeps a sliding window of the last three
//   accepted unsigned samples and emits one registered median per accepted
//   sample once the window is full.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   CLEAR      synchronous window flush, active-high, highest priority
//   IN_VALID   upstream sample valid
//   IN_READY   block can accept a sample this cycle
//   IN_DATA    upstream sample (WIDTH bits, unsigned)
//   OUT_VALID  OUT_DATA holds a median
//   OUT_READY  downstream accepts OUT_DATA
//   OUT_DATA   registered median of the window
//   FILL       number of valid window entries (0..3)
module median3_stream_filter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CLEAR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       FILL
);

  // Only the two newest window entries are stored: the oldest entry of the
  // full window is always discarded by the next shift before it could be
  // used, and the post-shift window for a median is {w1_q, w2_q, IN_DATA}.
  logic [WIDTH-1:0] w1_q;
  logic [WIDTH-1:0] w2_q;
  logic [1:0]       fill_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  // Reset release synchroniser: the block stays inert until the first
  // rising edge after rst_n deasserts, so the first accept can happen on
  // the second edge.
  logic             run_q;

  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] median_next;

  function automatic logic [WIDTH-1:0] med3(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      return lo;
    else if (c > hi) return hi;
    else             return c;
  endfunction

  always_comb begin
    IN_READY    = run_q && !CLEAR &&
                  ((fill_q < 2'd2) || !out_valid_q || OUT_READY);
    accept      = IN_VALID && IN_READY;
    transfer    = out_valid_q && OUT_READY;
    median_next = med3(w1_q, w2_q, IN_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_q        <= '0;
      w2_q        <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (CLEAR) begin
      w1_q        <= '0;
      w2_q        <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        w1_q <= w2_q;
        w2_q <= IN_DATA;
        if (fill_q != 2'd3) begin
          fill_q <= fill_q + 2'd1;
        end
      end
      // An accept that leaves the window full loads a new median; this
      // also covers a same-cycle transfer, keeping one sample per clock.
      if (accept && (fill_q >= 2'd2)) begin
        out_valid_q <= 1'b1;
        out_data_q  <= median_next;
      end else if (transfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign FILL      = fill_q;

endmodule

// File: tb/tb_median3_stream_filter.sv
module tb_median3_stream_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       CLEAR = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] IN_DATA = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [3:0] OUT_DATA;
  logic [1:0] FILL;

  int errors = 0;
  int checks = 0;

  median3_stream_filter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .CLEAR(CLEAR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .FILL(FILL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference median from a sorted copy of the window.
  function automatic int sort_median(input int a, input int b, input int c);
    int q[$];
    q = {a, b, c};
    q.sort();
    return q[1];
  endfunction

  // Reference median by the betweenness rule.
  function automatic int rule_median(input int a, input int b, input int c);
    if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
    if ((a <= c && c <= b) || (b <= c && c <= a)) return c;
    return a;
  endfunction

  // ---------------- behavioural model ----------------
  int win[$];
  int m_valid = 0;
  int m_data = 0;
  int m_run = 0;

  function automatic int m_ready();
    return (m_run != 0 && !CLEAR &&
            (win.size() < 2 || m_valid == 0 || OUT_READY)) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        win.delete();
        m_valid = 0;
        m_data  = 0;
        m_run   = 0;
      end else begin
        int acc;
        int xfer;
        acc  = (IN_VALID && m_ready() != 0) ? 1 : 0;
        xfer = (m_valid != 0 && OUT_READY) ? 1 : 0;
        if (CLEAR) begin
          win.delete();
          m_valid = 0;
        end else if (acc != 0) begin
          win.push_back(int'(IN_DATA));
          if (win.size() > 3) void'(win.pop_front());
          if (win.size() == 3) begin
            m_valid = 1;
            m_data  = sort_median(win[0], win[1], win[2]);
          end
        end else if (xfer != 0) begin
          m_valid = 0;
        end
        m_run = 1;
      end
    end
  end

  // Compare process: every falling edge, DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("fill", int'(FILL), win.size());
      chk("out_valid", int'(OUT_VALID), m_valid);
      chk("in_ready", int'(IN_READY), m_ready());
      if (m_valid != 0) chk("out_data", int'(OUT_DATA), m_data);
    end
  end

  task automatic step(input logic v, input logic [3:0] d,
                      input logic ordy, input logic clr);
    IN_VALID  = v;
    IN_DATA   = d;
    OUT_READY = ordy;
    CLEAR     = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] a4, b4, c4;

    // Model pins
    chk("pin_sort_591", sort_median(5, 1, 9), 5);
    chk("pin_sort_337", sort_median(3, 3, 7), 3);
    chk("pin_rule_2150", rule_median(2, 15, 0), 2);
    chk("pin_rule_777", rule_median(7, 7, 7), 7);

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fill", int'(FILL), 0);
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_data", int'(OUT_DATA), 0);
    chk("rst_in_ready", int'(IN_READY), 0);
    rst_n = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b0);   // synchroniser edge

    // Fill and first output
    step(1'b1, 4'd5, 1'b1, 1'b0);
    chk("fill1", int'(FILL), 1);
    chk("noout1", int'(OUT_VALID), 0);
    step(1'b1, 4'd1, 1'b1, 1'b0);
    chk("fill2", int'(FILL), 2);
    chk("noout2", int'(OUT_VALID), 0);
    step(1'b1, 4'd9, 1'b1, 1'b0);
    chk("fill3", int'(FILL), 3);
    chk("first_valid", int'(OUT_VALID), 1);
    chk("first_data", int'(OUT_DATA), 5);

    // Sliding at full rate
    step(1'b1, 4'd2, 1'b1, 1'b0);
    chk("slide_a", int'(OUT_DATA), 2);
    step(1'b1, 4'd2, 1'b1, 1'b0);
    chk("slide_b", int'(OUT_DATA), 2);
    step(1'b1, 4'd15, 1'b1, 1'b0);
    chk("slide_c", int'(OUT_DATA), 2);
    step(1'b1, 4'd0, 1'b1, 1'b0);
    chk("slide_d", int'(OUT_DATA), 2);
    chk("slide_valid", int'(OUT_VALID), 1);

    // Backpressure: window now 2,15,0
    IN_VALID = 1'b1; IN_DATA = 4'd11; OUT_READY = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", int'(IN_READY), 0);
      chk("bp_data", int'(OUT_DATA), 2);
      chk("bp_valid", int'(OUT_VALID), 1);
      @(posedge clk);
    end
    #1;
    step(1'b1, 4'd11, 1'b1, 1'b0);
    chk("bp_resume", int'(OUT_DATA), 11);   // 15,0,11
    step(1'b1, 4'd4, 1'b1, 1'b0);
    chk("bp_next", int'(OUT_DATA), 4);      // 0,11,4

    // CLEAR in FULL with pending output
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_DATA = 4'd7; CLEAR = 1'b1;
    #1;
    chk("clr_in_ready", int'(IN_READY), 0);
    @(posedge clk);
    #1;
    chk("clr_fill", int'(FILL), 0);
    chk("clr_valid", int'(OUT_VALID), 0);
    step(1'b1, 4'd4, 1'b1, 1'b0);
    chk("clr_no1", int'(OUT_VALID), 0);
    step(1'b1, 4'd8, 1'b1, 1'b0);
    chk("clr_no2", int'(OUT_VALID), 0);
    step(1'b1, 4'd6, 1'b1, 1'b0);
    chk("clr_valid6", int'(OUT_VALID), 1);
    chk("clr_data6", int'(OUT_DATA), 6);

    // Async reset mid-stream, between edges
    step(1'b1, 4'd13, 1'b0, 1'b0);
    chk("ar_pre_valid", int'(OUT_VALID), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(OUT_VALID), 0);
    chk("ar_data", int'(OUT_DATA), 0);
    chk("ar_fill", int'(FILL), 0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 4'd3, 1'b1, 1'b0);
    chk("ar_sync_fill", int'(FILL), 0);     // still synchronising
    step(1'b1, 4'd3, 1'b1, 1'b0);
    step(1'b1, 4'd7, 1'b1, 1'b0);
    step(1'b1, 4'd3, 1'b1, 1'b0);
    chk("ar_refill", int'(OUT_DATA), 3);    // 3,7,3

    // Exhaustive triples
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        for (int unsigned c = 0; c < 16; c++) begin
          a4 = a[3:0]; b4 = b[3:0]; c4 = c[3:0];
          step(1'b0, 4'd0, 1'b1, 1'b1);
          step(1'b1, a4, 1'b1, 1'b0);
          step(1'b1, b4, 1'b1, 1'b0);
          step(1'b1, c4, 1'b1, 1'b0);
          chk("triple_valid", int'(OUT_VALID), 1);
          chk($sformatf("triple_%0d_%0d_%0d", a, b, c), int'(OUT_DATA),
              rule_median(int'(a), int'(b), int'(c)));
        end
      end
    end

    // Randomised traffic against the model
    step(1'b0, 4'd0, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) != 0,
           ($urandom % 60) == 0);
    end
    step(1'b0, 4'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
